// File: rtl/seq_player.sv
// Sequence playback controller: reads colors from the sequence memory and shows each on a one-hot LED bus.
// Optional macro SEQ_PLAYER_LEVEL_SPEED_EN shortens the LED on-time as the game level rises.
module seq_player #(
    parameter int ADDR_W     = 4,
    parameter int COLOR_W    = 2,
    parameter int ON_CYCLES  = 8,
    parameter int OFF_CYCLES = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      play,
    input  logic                      abort,
    input  logic [ADDR_W:0]           length,
    input  logic [2:0]                level,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_rd,
    input  logic [COLOR_W-1:0]        mem_data,
    output logic [(1<<COLOR_W)-1:0]   led,
    output logic                      edisplay,
    output logic                      busy,
    output logic                      done,
    output logic [2:0]                dbg_state,
    output logic [2:0]                dbg_level
);

    localparam int LED_W   = 1 << COLOR_W;
    localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TIMER_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        LATCH = 3'd2,
        SHOW  = 3'd3,
        GAP   = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t              state_q;
    logic [ADDR_W:0]     idx_q;
    logic [ADDR_W:0]     len_q;
    logic [2:0]          level_q;
    logic [TIMER_W-1:0]  timer_q;
    logic [COLOR_W-1:0]  color_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                mem_rd_q;
    logic [LED_W-1:0]    led_q;
    logic                edisplay_q;
    logic                busy_q;
    logic                done_q;

    logic [ADDR_W:0]     idx_inc_d;
    logic [ADDR_W:0]     len_m1_d;
    logic [TIMER_W-1:0]  on_m1_d;
    int                  on_cycles_d;

    assign idx_inc_d = idx_q + (ADDR_W+1)'(1);
    assign len_m1_d  = len_q - (ADDR_W+1)'(1);

    // On-time uses the level captured when play was accepted, never the live input.
    always_comb begin
        on_cycles_d = ON_CYCLES;
`ifdef SEQ_PLAYER_LEVEL_SPEED_EN
        on_cycles_d = ON_CYCLES >> level_q;
        if (on_cycles_d < 1) begin
            on_cycles_d = 1;
        end
`endif
    end

    assign on_m1_d = TIMER_W'(on_cycles_d - 1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            len_q      <= '0;
            level_q    <= '0;
            timer_q    <= '0;
            color_q    <= '0;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            led_q      <= '0;
            edisplay_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else if (abort && (state_q != IDLE)) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            timer_q    <= '0;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            led_q      <= '0;
            edisplay_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (play) begin
                        len_q   <= length;
                        level_q <= level;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        if (length != '0) begin
                            state_q    <= READ;
                            mem_rd_q   <= 1'b1;
                            mem_addr_q <= '0;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    mem_rd_q <= 1'b0;
                    state_q  <= LATCH;
                end
                LATCH: begin
                    color_q    <= mem_data;
                    timer_q    <= on_m1_d;
                    led_q      <= LED_W'(1) << mem_data;
                    edisplay_q <= 1'b1;
                    state_q    <= SHOW;
                end
                SHOW: begin
                    if (timer_q == '0) begin
                        timer_q    <= TIMER_W'(OFF_CYCLES - 1);
                        led_q      <= '0;
                        edisplay_q <= 1'b0;
                        state_q    <= GAP;
                    end else begin
                        timer_q <= timer_q - TIMER_W'(1);
                        led_q   <= LED_W'(1) << color_q;
                    end
                end
                GAP: begin
                    if (timer_q == '0) begin
                        // idx is one bit wider than the address so a full-depth sequence ends without wrapping.
                        if (idx_q == len_m1_d) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q      <= idx_inc_d;
                            mem_addr_q <= idx_inc_d[ADDR_W-1:0];
                            mem_rd_q   <= 1'b1;
                            state_q    <= READ;
                        end
                    end else begin
                        timer_q <= timer_q - TIMER_W'(1);
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q    <= IDLE;
                    mem_rd_q   <= 1'b0;
                    led_q      <= '0;
                    edisplay_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_rd    = mem_rd_q;
    assign led       = led_q;
    assign edisplay  = edisplay_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;
    assign dbg_level = level_q;

endmodule

// File: tb/tb_seq_player.sv
// Bench for seq_player: a memory model feeds the DUT and a per-cycle expected queue checks every output.
module tb_seq_player;

  localparam int ADDR_W  = 4;
  localparam int COLOR_W = 2;
  localparam int ON      = 4;
  localparam int OFF     = 2;
  localparam int W       = 12;

  logic              clock = 1'b0;
  logic              reset;
  logic              play;
  logic              abort;
  logic [ADDR_W:0]   length;
  logic [2:0]        level;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [COLOR_W-1:0] mem_data = '0;
  logic [3:0]        led;
  logic              edisplay;
  logic              busy;
  logic              done;
  logic [2:0]        dbg_state;
  logic [2:0]        dbg_level;

  logic [COLOR_W-1:0] tb_mem [16];
  logic [W-1:0]       exp_q[$];
  int                 errors = 0;
  int                 checks = 0;

  seq_player #(
    .ADDR_W(ADDR_W), .COLOR_W(COLOR_W), .ON_CYCLES(ON), .OFF_CYCLES(OFF)
  ) dut (
    .clock(clock), .reset(reset), .play(play), .abort(abort),
    .length(length), .level(level), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_data(mem_data), .led(led), .edisplay(edisplay), .busy(busy),
    .done(done), .dbg_state(dbg_state), .dbg_level(dbg_level)
  );

  // clock / memory model
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_rd) mem_data <= tb_mem[mem_addr];
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  function automatic int on_time(input int lvl);
    int v;
`ifdef SEQ_PLAYER_LEVEL_SPEED_EN
    v = ON >> lvl;
    if (v < 1) v = 1;
`else
    v = ON;
`endif
    return v;
  endfunction

  function automatic logic [W-1:0] pk(input logic rd, input logic [3:0] a, input logic [3:0] l,
                                      input logic ed, input logic b, input logic d);
    return {rd, a, l, ed, b, d};
  endfunction

  // driver: expected per-cycle outputs of one full playback, starting at cycle t0+1
  task automatic push_expected(input int len, input int lvl);
    logic [3:0] one_hot;
    for (int k = 0; k < len; k++) begin
      one_hot = 4'b0001 << tb_mem[k];
      exp_q.push_back(pk(1'b1, 4'(k), 4'b0, 1'b0, 1'b1, 1'b0));
      exp_q.push_back(pk(1'b0, 4'b0, 4'b0, 1'b0, 1'b1, 1'b0));
      for (int j = 0; j < on_time(lvl); j++)
        exp_q.push_back(pk(1'b0, 4'b0, one_hot, 1'b1, 1'b1, 1'b0));
      for (int j = 0; j < OFF; j++)
        exp_q.push_back(pk(1'b0, 4'b0, 4'b0, 1'b0, 1'b1, 1'b0));
    end
    exp_q.push_back(pk(1'b0, 4'b0, 4'b0, 1'b0, 1'b1, 1'b1));
    exp_q.push_back(pk(1'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0));
  endtask

  // cut_kind: 1 = abort at end of cycle 'cut', 2 = reset at end of cycle 'cut'
  task automatic run_play(input int len, input int lvl, input int cut, input int cut_kind,
                          input int replay_cyc, input logic with_abort, input string name);
    logic [W-1:0] e;
    logic [W-1:0] o;
    int i;
    @(negedge clock);
    push_expected(len, lvl);
    if (cut > 0) begin
      while (exp_q.size() > cut) void'(exp_q.pop_back());
      exp_q.push_back(pk(1'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0));
    end
    play   = 1'b1;
    length = 5'(len);
    level  = 3'(lvl);
    abort  = with_abort;
    @(negedge clock);
    play  = 1'b0;
    abort = 1'b0;
    i = 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = {mem_rd, (mem_rd ? mem_addr : 4'd0), led, edisplay, busy, done};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s t0+%0d: got rd=%b addr=%0d led=%b en=%b busy=%b done=%b, expected rd=%b addr=%0d led=%b en=%b busy=%b done=%b",
                 name, i, o[11], o[10:7], o[6:3], o[2], o[1], o[0],
                 e[11], e[10:7], e[6:3], e[2], e[1], e[0]);
      end
      abort = (cut_kind == 1) && (i == cut);
      reset = (cut_kind == 2) && (i == cut);
      if (i == replay_cyc) begin
        play   = 1'b1;
        length = 5'd1;
        level  = 3'd7;
      end else begin
        play = 1'b0;
      end
      @(negedge clock);
      i++;
    end
    abort = 1'b0;
    reset = 1'b0;
    play  = 1'b0;
  endtask

  task automatic load_basic_mem();
    tb_mem[0] = 2'd2;
    tb_mem[1] = 2'd0;
    tb_mem[2] = 2'd3;
  endtask

  task automatic test_reset();
    reset = 1'b1; play = 1'b0; abort = 1'b0; length = '0; level = '0;
    repeat (3) @(negedge clock);
    checks++; if (mem_rd !== 1'b0)    begin errors++; $display("FAIL reset_mem_rd: got %b expected 0", mem_rd); end
    checks++; if (mem_addr !== 4'd0)  begin errors++; $display("FAIL reset_mem_addr: got %0d expected 0", mem_addr); end
    checks++; if (led !== 4'd0)       begin errors++; $display("FAIL reset_led: got %b expected 0000", led); end
    checks++; if (edisplay !== 1'b0)  begin errors++; $display("FAIL reset_edisplay: got %b expected 0", edisplay); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    reset = 1'b0;
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    @(negedge clock);
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL idle_abort_busy: got %b expected 0", busy); end
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL idle_abort_state: got %0d expected 0", dbg_state); end
  endtask

  task automatic test_basic();
    load_basic_mem();
    run_play(3, 0, 0, 0, 0, 1'b0, "basic");
  endtask

  task automatic test_levels();
    tb_mem[0] = 2'd1;
    run_play(1, 1, 0, 0, 0, 1'b0, "level1");
    tb_mem[0] = 2'd3;
    run_play(1, 2, 0, 0, 0, 1'b0, "level2");
    run_play(1, 7, 0, 0, 0, 1'b0, "level7");
  endtask

  task automatic test_zero_length();
    run_play(0, 0, 0, 0, 0, 1'b0, "zero_length");
  endtask

  task automatic test_full_length();
    for (int k = 0; k < 16; k++) tb_mem[k] = 2'($urandom_range(0, 3));
    run_play(16, 0, 0, 0, 0, 1'b0, "full_length");
  endtask

  task automatic test_abort();
    load_basic_mem();
    run_play(3, 0, 12, 1, 0, 1'b0, "abort_show2");
    run_play(3, 0, 0, 0, 0, 1'b0, "restart_after_abort");
  endtask

  task automatic test_replay_busy();
    load_basic_mem();
    run_play(3, 0, 0, 0, 5, 1'b0, "replay_busy");
  endtask

  task automatic test_reset_mid_gap();
    load_basic_mem();
    run_play(3, 0, 7, 2, 0, 1'b0, "reset_gap");
  endtask

  task automatic test_play_with_abort();
    load_basic_mem();
    run_play(2, 0, 0, 0, 0, 1'b1, "play_with_abort");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) tb_mem[k] = 2'($urandom_range(0, 3));
    run_play(4, 0, 0, 0, 0, 1'b0, "back_to_back_a");
    run_play(2, 1, 0, 0, 0, 1'b0, "back_to_back_b");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_levels();
    test_zero_length();
    test_full_length();
    test_abort();
    test_replay_busy();
    test_reset_mid_gap();
    test_play_with_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_player.md
# seq_player

Sequence playback controller for the color-memory game. On a `play` request it walks the sequence memory from address 0 to `length-1`, reading one color per step. Each color is shown on the one-hot LED bus for a level-dependent on-time, followed by a dark gap. It sits between the game controller (which issues `play` and the sequence length) and the sequence memory / LED driver, and owns the memory read port and `edisplay` while busy.

## Interface
Parameters:
- `ADDR_W`, 4: memory address width; max sequence 2^ADDR_W.
- `COLOR_W`, 2: color code width; LED bus is 2^COLOR_W wide.
- `ON_CYCLES`, 8: base LED on-time in clocks; must be ≥1.
- `OFF_CYCLES`, 2: gap between colors in clocks; must be ≥1.

Ports:
- `clock` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `play` in 1: start request, sampled only in IDLE.
- `abort` in 1: stop playback, highest priority after `reset`.
- `length` in ADDR_W+1: number of entries to play, 0..2^ADDR_W; latched on accepted `play`.
- `level` in 3: game level; shortens on-time.
- `mem_addr` out ADDR_W: read address.
- `mem_rd` out 1: read strobe; memory returns `mem_data` one clock later.
- `mem_data` in COLOR_W: read data.
- `led` out 2^COLOR_W: one-hot color, all-zero when dark.
- `edisplay` out 1: LED enable; high only in SHOW.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at normal completion.

## Operation
- Registered state and outputs.
- Reset: state IDLE, idx 0, timer 0, color 0. All outputs are 0: `mem_addr`, `mem_rd`, `led`, `edisplay`, `busy`, `done`.
- States and transitions:
  - IDLE:
    - `play` with `length`≠0 → latch length, idx=0, go to READ.
    - `play` with `length`=0 → go to DONE with no memory access.
    - Otherwise stay.
  - READ: `mem_rd`=1, `mem_addr`=idx; → LATCH.
  - LATCH: color←`mem_data`, timer←on−1; → SHOW.
  - SHOW: `edisplay`=1, `led`=1<<color; timer decrements.
    - At 0: timer←OFF_CYCLES−1, go to GAP.
  - GAP: `led`=0, `edisplay`=0; timer decrements.
    - At 0 with idx==length−1 → DONE.
    - At 0 otherwise: idx+1, go to READ.
  - DONE: `done`=1 for one cycle; → IDLE.
- On-time = max(1, ON_CYCLES >> `level`). The timer is wide enough for max(ON_CYCLES, OFF_CYCLES).
- idx is ADDR_W+1 bits wide. `length`=2^ADDR_W plays addresses 0..2^ADDR_W−1 with no wrap; `mem_addr` is idx[ADDR_W−1:0].
- `abort` in any non-IDLE state → IDLE next cycle, all outputs low, no `done` pulse. `abort` in IDLE is ignored. `abort` and `play` together in IDLE: `play` wins.
- `play` while busy is ignored, not queued. Changes to `length` or `level` while busy have no effect on the current playback, because both are captured at acceptance.

## Timing
- Let t0 be the edge that samples `play`. READ occupies cycle t0+1.
- Per element P = 2 + on + OFF_CYCLES cycles. Element k spans cycles t0+1+kP .. t0+(k+1)P.
- `done` is high during cycle t0+N·P+1; `busy` falls the following cycle.
- With `length`=0, `done` is high at t0+1.
- `reset` mid-playback: outputs are 0 from the next edge.

## Configuration
- `SEQ_PLAYER_LEVEL_SPEED_EN`:
  - Defined: on-time = max(1, ON_CYCLES >> `level`).
  - Undefined: `level` is ignored and on-time = ON_CYCLES. The port remains present.

## Test plan
- ON=4, OFF=2, `level`=0, memory {2,0,3}, `length`=3, `play` at t0:
  - `led` shows 0100, 0001, 1000, each 4 cycles with 2 dark cycles between.
  - `done` high at t0+25; `mem_rd` pulses at t0+1, +9, +17.
- ON=8, `SEQ_PLAYER_LEVEL_SPEED_EN` defined:
  - `level`=2 gives 2-cycle SHOW.
  - `level`=7 gives 1-cycle SHOW.
  - Macro undefined: 8 cycles for both.
- `length`=0 with `play`: `done` at t0+1, `mem_rd` never asserted.
- `length`=16 with ADDR_W=4: `mem_addr` steps 0..15 and then stops; `done` at t0+16P+1.
- `abort` during the second SHOW: IDLE next cycle, `led`=0, `busy`=0, no `done`. A new `play` then restarts from address 0.
- `play` re-pulsed while busy is ignored, and timing is unchanged. `reset` mid-GAP: all outputs 0 the next cycle.
